// File: rtl/processor_pkg.sv
// Shared processor definitions: PC width, opcodes, instruction field positions
// and the fetch-stage state encoding (FETCH_HALTED exists only with IFETCH_HALT_EN).
package processor_pkg;

    localparam int PC_WIDTH = 26;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 20;
    localparam int RT_MSB     = 19;
    localparam int RT_LSB     = 14;
    localparam int RD_MSB     = 13;
    localparam int RD_LSB     = 8;
    localparam int SHAMT_MSB  = 7;
    localparam int SHAMT_LSB  = 4;
    localparam int FUNCT_MSB  = 3;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 13;
    localparam int IMM_LSB    = 0;
    localparam int JUMP_MSB   = 25;
    localparam int JUMP_LSB   = 0;

    localparam logic [5:0] OP_ALU  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_LW   = 6'h02;
    localparam logic [5:0] OP_SW   = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h06;
    localparam logic [5:0] OP_JAL  = 6'h07;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_FULL
`ifdef IFETCH_HALT_EN
        , FETCH_HALTED
`endif
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for an instruction acknowledged while the decoder stalls.
// Flush wins over load, which wins over unload.
module fetch_skid_buffer
    import processor_pkg::*;
#(
    parameter int PC_WIDTH = processor_pkg::PC_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                unload,
    input  logic                flush,
    input  logic [31:0]         load_word,
    input  logic [PC_WIDTH-1:0] load_pc,
    output logic                full,
    output logic [31:0]         word,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            word <= '0;
            pc   <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            word <= load_word;
            pc   <= load_pc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, runs a single-outstanding imem handshake, absorbs
// stalls in a skid buffer and takes redirects. IFETCH_HALT_EN adds a HALT stop state.
module instruction_fetch
    import processor_pkg::*;
#(
    parameter int                  PC_WIDTH = processor_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic [31:0]         instruction_reg,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                instr_valid
);

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic                drop_pending;
    logic                ack_seen;
    logic                skid_load;
    logic                skid_unload;
    logic                skid_full;
    logic [31:0]         skid_word;
    logic [PC_WIDTH-1:0] skid_pc;

    // Acks while no request is up (e.g. just after reset) belong to nobody.
    assign ack_seen    = imem_req & imem_ack;
    assign pc_next     = pc + 1'b1;
    assign skid_load   = ack_seen & ~drop_pending & stall & ~redirect_valid
                         & (state != FETCH_FULL);
    assign skid_unload = (state == FETCH_FULL) & skid_full & ~stall & ~redirect_valid;

    fetch_skid_buffer #(.PC_WIDTH(PC_WIDTH)) u_skid (
        .clock     (clock),
        .reset     (reset),
        .load      (skid_load),
        .unload    (skid_unload),
        .flush     (redirect_valid),
        .load_word (imem_rdata),
        .load_pc   (imem_addr),
        .full      (skid_full),
        .word      (skid_word),
        .pc        (skid_pc)
    );

    // imem_addr is separate from pc so a stale in-flight request keeps a stable
    // address after a redirect; the target goes out once that request is acked.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= FETCH_REQ;
            pc              <= RESET_PC;
            imem_req        <= 1'b0;
            imem_addr       <= RESET_PC;
            instruction_reg <= '0;
            instr_pc        <= RESET_PC;
            instr_valid     <= 1'b0;
            drop_pending    <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            if (redirect_valid) begin
                pc <= redirect_target;
                if (ack_seen || !imem_req) begin
                    imem_req     <= 1'b1;
                    imem_addr    <= redirect_target;
                    drop_pending <= 1'b0;
                    state        <= FETCH_REQ;
                end else begin
                    drop_pending <= 1'b1;
                    state        <= FETCH_WAIT;
                end
            end else if (drop_pending) begin
                if (ack_seen) begin
                    drop_pending <= 1'b0;
                    imem_addr    <= pc;
                    state        <= FETCH_REQ;
                end
            end else begin
                case (state)
                    FETCH_REQ, FETCH_WAIT: begin
                        if (!imem_req) begin
                            imem_req <= 1'b1;
                        end else if (imem_ack) begin
                            pc        <= pc_next;
                            imem_addr <= pc_next;
                            if (stall) begin
                                imem_req <= 1'b0;
                                state    <= FETCH_FULL;
                            end else begin
                                instruction_reg <= imem_rdata;
                                instr_pc        <= imem_addr;
                                instr_valid     <= 1'b1;
`ifdef IFETCH_HALT_EN
                                if (opcode_of(imem_rdata) == OP_HALT) begin
                                    imem_req <= 1'b0;
                                    state    <= FETCH_HALTED;
                                end else begin
                                    state <= FETCH_REQ;
                                end
`else
                                state <= FETCH_REQ;
`endif
                            end
                        end else begin
                            state <= FETCH_WAIT;
                        end
                    end
                    FETCH_FULL: begin
                        if (skid_unload) begin
                            instruction_reg <= skid_word;
                            instr_pc        <= skid_pc;
                            instr_valid     <= 1'b1;
`ifdef IFETCH_HALT_EN
                            if (opcode_of(skid_word) == OP_HALT) begin
                                state <= FETCH_HALTED;
                            end else begin
                                imem_req <= 1'b1;
                                state    <= FETCH_REQ;
                            end
`else
                            imem_req <= 1'b1;
                            state    <= FETCH_REQ;
`endif
                        end
                    end
`ifdef IFETCH_HALT_EN
                    FETCH_HALTED: begin
                        imem_req <= 1'b0;
                    end
`endif
                    default: begin
                        state <= FETCH_REQ;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, zero-wait stream, stall/skid,
// redirects (in flight and coincident with ack), async reset, optional HALT.
module tb_instruction_fetch;

    localparam int PCW = 26;

    logic            clock = 1'b0;
    logic            reset;
    logic            imem_req;
    logic [PCW-1:0]  imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            stall;
    logic            redirect_valid;
    logic [PCW-1:0]  redirect_target;
    logic [31:0]     instruction_reg;
    logic [PCW-1:0]  instr_pc;
    logic            instr_valid;

    logic            tie_ack;
    logic            ack_drv;
    logic [31:0]     rdata_drv;

    int              total_count = 0;
    int              pass_count  = 0;

    always #5 clock = ~clock;

    // Zero-wait memory mode: ack follows req, data is 0x04000001 + address.
    assign imem_ack   = tie_ack ? imem_req : ack_drv;
    assign imem_rdata = tie_ack ? (32'h0400_0001 + {6'd0, imem_addr}) : rdata_drv;

    instruction_fetch dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instruction_reg (instruction_reg),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic stl,
                                 input logic redir, input logic [PCW-1:0] target);
        ack_drv         = ack;
        rdata_drv       = rdata;
        stall           = stl;
        redirect_valid  = redir;
        redirect_target = target;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        tie_ack = 1'b0;
        ack_drv = 1'b0;
        rdata_drv = '0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("rst_req",   {31'd0, imem_req}, 32'd0);
        checkOutput("rst_addr",  {6'd0, imem_addr}, 32'd0);
        checkOutput("rst_instr", instruction_reg, 32'd0);
        checkOutput("rst_ipc",   {6'd0, instr_pc}, 32'd0);
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);

        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("first_req",  {31'd0, imem_req}, 32'd1);
        checkOutput("first_addr", {6'd0, imem_addr}, 32'd0);

        tie_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
            checkOutput("zw_instr", instruction_reg, 32'h0400_0001 + i);
            checkOutput("zw_ipc",   {6'd0, instr_pc}, i);
            checkOutput("zw_valid", {31'd0, instr_valid}, 32'd1);
        end
        tie_ack = 1'b0;

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0);
        checkOutput("stw_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("stw_instr", instruction_reg, 32'h0400_0003);
        checkOutput("stw_req",   {31'd0, imem_req}, 32'd1);
        applyStimulus(1'b1, 32'hAAAA_0000, 1'b1, 1'b0, '0);
        checkOutput("stack_req",   {31'd0, imem_req}, 32'd0);
        checkOutput("stack_instr", instruction_reg, 32'h0400_0003);
        checkOutput("stack_valid", {31'd0, instr_valid}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0);
        checkOutput("full_req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("unl_instr", instruction_reg, 32'hAAAA_0000);
        checkOutput("unl_ipc",   {6'd0, instr_pc}, 32'd3);
        checkOutput("unl_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("unl_req",   {31'd0, imem_req}, 32'd1);
        checkOutput("unl_addr",  {6'd0, imem_addr}, 32'd4);

        applyStimulus(1'b1, 32'h1111_1111, 1'b0, 1'b0, '0);
        checkOutput("pc4_instr", instruction_reg, 32'h1111_1111);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("wait5_addr", {6'd0, imem_addr}, 32'd5);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 26'h100);
        checkOutput("drop_addr",  {6'd0, imem_addr}, 32'd5);
        checkOutput("drop_req",   {31'd0, imem_req}, 32'd1);
        checkOutput("drop_valid", {31'd0, instr_valid}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
        checkOutput("stale_instr", instruction_reg, 32'h1111_1111);
        checkOutput("stale_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("tgt_addr",    {6'd0, imem_addr}, 32'h100);
        checkOutput("tgt_req",     {31'd0, imem_req}, 32'd1);
        applyStimulus(1'b1, 32'h2222_2222, 1'b0, 1'b0, '0);
        checkOutput("tgt_instr", instruction_reg, 32'h2222_2222);
        checkOutput("tgt_ipc",   {6'd0, instr_pc}, 32'h100);

        applyStimulus(1'b1, 32'h3333_3333, 1'b0, 1'b1, 26'h200);
        checkOutput("coin_instr", instruction_reg, 32'h2222_2222);
        checkOutput("coin_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("coin_addr",  {6'd0, imem_addr}, 32'h200);
        checkOutput("coin_req",   {31'd0, imem_req}, 32'd1);
        applyStimulus(1'b1, 32'h4444_4444, 1'b0, 1'b0, '0);
        checkOutput("coin2_instr", instruction_reg, 32'h4444_4444);
        checkOutput("coin2_ipc",   {6'd0, instr_pc}, 32'h200);

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        #1;
        checkOutput("mrst_req",   {31'd0, imem_req}, 32'd0);
        checkOutput("mrst_addr",  {6'd0, imem_addr}, 32'd0);
        checkOutput("mrst_instr", instruction_reg, 32'd0);
        checkOutput("mrst_valid", {31'd0, instr_valid}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        applyStimulus(1'b1, 32'hBADB_AD00, 1'b0, 1'b0, '0);
        checkOutput("rel_instr", instruction_reg, 32'd0);
        checkOutput("rel_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rel_req",   {31'd0, imem_req}, 32'd1);
        applyStimulus(1'b1, 32'h5555_5555, 1'b0, 1'b0, '0);
        checkOutput("rel2_instr", instruction_reg, 32'h5555_5555);
        checkOutput("rel2_ipc",   {6'd0, instr_pc}, 32'd0);

        applyStimulus(1'b1, 32'hFC00_0000, 1'b0, 1'b0, '0);
        checkOutput("halt_instr", instruction_reg, 32'hFC00_0000);
        checkOutput("halt_valid", {31'd0, instr_valid}, 32'd1);
`ifdef IFETCH_HALT_EN
        checkOutput("halt_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
            checkOutput("halted_req", {31'd0, imem_req}, 32'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 26'h20);
        checkOutput("resume_req",  {31'd0, imem_req}, 32'd1);
        checkOutput("resume_addr", {6'd0, imem_addr}, 32'h20);
`else
        checkOutput("nohalt_req",  {31'd0, imem_req}, 32'd1);
        checkOutput("nohalt_addr", {6'd0, imem_addr}, 32'd2);
`endif

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
